// File: rtl/adder_controller_if.sv
// Keypad key stream and adder operand/handshake bus shared by adder_controller and its peers.
interface adder_controller_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [11:0] number1;
   logic [11:0] number2;
   logic        add_enable;
   logic [11:0] sum_result;
   logic        sum_state;

   modport master (
      input  key_valid, key_code, sum_result, sum_state,
      output number1, number2, add_enable
   );

   modport slave (
      output key_valid, key_code, sum_result, sum_state,
      input  number1, number2, add_enable
   );
endinterface

// File: rtl/adder_controller.sv
// Keypad-driven operand builder and adder sequencer with timeout on the adder done strobe.
// Optional running-total chaining ('+' in DONE) is enabled by defining ADDER_CTRL_CHAIN_EN.
//
// state     | meaning
// ENTER_A   | accumulating digits of operand A
// ENTER_B   | accumulating digits of operand B
// ADD       | one-cycle adder enable pulse
// WAIT      | waiting for sum_state, timeout counter running
// DONE      | result (or error) held for display
module adder_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   adder_controller_if.master bus,
   output logic [11:0]       result,
   output logic              result_valid,
   output logic              error,
   output logic              busy,
   output logic              entry_sel,
   output logic [1:0]        digit_count
);

   typedef enum logic [2:0] {
      S_ENTER_A,
      S_ENTER_B,
      S_ADD,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [11:0] num1_q, num1_d;
   logic [11:0] num2_q, num2_d;
   logic [11:0] result_q, result_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;
   logic [1:0]  dcnt_q, dcnt_d;
   logic [7:0]  tmr_q, tmr_d;

   logic        is_digit, is_plus, is_eq, is_clr;
   logic [11:0] digit_ext;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_ENTER_A;
         num1_q   <= '0;
         num2_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         dcnt_q   <= '0;
         tmr_q    <= '0;
      end else begin
         state_q  <= state_d;
         num1_q   <= num1_d;
         num2_q   <= num2_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         dcnt_q   <= dcnt_d;
         tmr_q    <= tmr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      num1_d    = num1_q;
      num2_d    = num2_q;
      result_d  = result_q;
      valid_d   = valid_q;
      error_d   = error_q;
      dcnt_d    = dcnt_q;
      tmr_d     = tmr_q;

      is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
      is_plus   = bus.key_valid && (bus.key_code == 4'hA);
      is_eq     = bus.key_valid && (bus.key_code == 4'hB);
      is_clr    = bus.key_valid && (bus.key_code == 4'hC);
      digit_ext = {8'd0, bus.key_code};

      case (state_q)
         S_ENTER_A: begin
            if (is_digit && dcnt_q != 2'd3) begin
               num1_d = num1_q * 12'd10 + digit_ext;
               dcnt_d = dcnt_q + 2'd1;
            end else if (is_plus) begin
               state_d = S_ENTER_B;
               dcnt_d  = '0;
            end
         end
         S_ENTER_B: begin
            if (is_digit && dcnt_q != 2'd3) begin
               num2_d = num2_q * 12'd10 + digit_ext;
               dcnt_d = dcnt_q + 2'd1;
            end else if (is_eq) begin
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            state_d = S_WAIT;
            tmr_d   = TMR_LOAD;
         end
         S_WAIT: begin
            // The done strobe wins over a timeout landing on the same edge.
            if (bus.sum_state) begin
               result_d = bus.sum_result;
               valid_d  = 1'b1;
               state_d  = S_DONE;
            end else if (tmr_q == 8'd0) begin
               error_d  = 1'b1;
               result_d = '0;
               state_d  = S_DONE;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         S_DONE: begin
            if (is_digit) begin
               num1_d  = digit_ext;
               num2_d  = '0;
               valid_d = 1'b0;
               error_d = 1'b0;
               dcnt_d  = 2'd1;
               state_d = S_ENTER_A;
            end
`ifdef ADDER_CTRL_CHAIN_EN
            else if (is_plus && !error_q) begin
               num1_d  = result_q;
               num2_d  = '0;
               valid_d = 1'b0;
               dcnt_d  = '0;
               state_d = S_ENTER_B;
            end
`endif
         end
         default: state_d = S_ENTER_A;
      endcase

      if (is_clr) begin
         num1_d   = '0;
         num2_d   = '0;
         result_d = '0;
         valid_d  = 1'b0;
         error_d  = 1'b0;
         dcnt_d   = '0;
         state_d  = S_ENTER_A;
      end
   end

   assign bus.number1    = num1_q;
   assign bus.number2    = num2_q;
   assign bus.add_enable = (state_q == S_ADD);
   assign result         = result_q;
   assign result_valid   = valid_q;
   assign error          = error_q;
   assign busy           = (state_q == S_ADD) || (state_q == S_WAIT);
   assign entry_sel      = (state_q == S_ENTER_B);
   assign digit_count    = dcnt_q;

endmodule

// File: tb/tb_adder_controller.sv
// Self-checking bench for adder_controller: vector table, timing corner cases and a random key stream.
module tb_adder_controller;

   localparam int TO = 8;

   logic        clk;
   logic        reset;
   logic [11:0] result;
   logic        result_valid, error, busy, entry_sel;
   logic [1:0]  digit_count;
   logic        hold;

   int tests = 0;
   int fails = 0;

   adder_controller_if bus();

   adder_controller #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.master),
      .result       (result),
      .result_valid (result_valid),
      .error        (error),
      .busy         (busy),
      .entry_sel    (entry_sel),
      .digit_count  (digit_count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Behavioural adder: registers the sum on enable, strobes done one cycle later unless held off.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.sum_state  <= 1'b0;
         bus.sum_result <= '0;
      end else begin
         bus.sum_state <= bus.add_enable && !hold;
         if (bus.add_enable) bus.sum_result <= bus.number1 + bus.number2;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [3:0] c, input int idle);
      bus.key_valid = 1'b1;
      bus.key_code  = c;
      tick();
      bus.key_valid = 1'b0;
      bus.key_code  = 4'hD;
      for (int i = 0; i < idle; i++) tick();
   endtask

   // Calculator-level reference model
   int ma, mb, mdc, mres, mph;
   bit mval, merr;

   task automatic model_clear();
      ma = 0; mb = 0; mdc = 0; mres = 0; mph = 0; mval = 0; merr = 0;
   endtask

   task automatic model_key(input logic [3:0] c);
      if (c == 4'hC) model_clear();
      else if (c <= 4'd9) begin
         if (mph == 2) begin
            ma = int'(c); mb = 0; mval = 0; merr = 0; mdc = 1; mph = 0;
         end else if (mdc < 3) begin
            if (mph == 0) ma = ma * 10 + int'(c);
            else          mb = mb * 10 + int'(c);
            mdc++;
         end
      end else if (c == 4'hA) begin
         if (mph == 0) begin
            mph = 1; mdc = 0;
         end
`ifdef ADDER_CTRL_CHAIN_EN
         else if (mph == 2 && !merr) begin
            ma = mres; mb = 0; mval = 0; mdc = 0; mph = 1;
         end
`endif
      end else if (c == 4'hB) begin
         if (mph == 1) begin
            mres = (ma + mb) % 4096; mval = 1; mph = 2;
         end
      end
   endtask

   typedef struct {
      logic [47:0] keys;
      int          n;
      int          res;
      int          valid;
      int          n1;
      int          n2;
      int          dc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] k;
      int r;

      vecs[0] = '{48'h0000_0B54_A321, 7, 168, 1, 123, 45, 2};
      vecs[1] = '{48'h00B9_999A_9999, 10, 1998, 1, 999, 999, 3};
      vecs[2] = '{48'h0000_0000_00BA, 2, 0, 1, 0, 0, 0};
      vecs[3] = '{48'h0000_B2AB_1FED, 8, 3, 1, 1, 2, 1};
      vecs[4] = '{48'h0000_000B_8AA7, 5, 15, 1, 7, 8, 1};
`ifdef ADDER_CTRL_CHAIN_EN
      vecs[5] = '{48'h0000_0B7A_B6A5, 7, 18, 1, 11, 7, 1};
`else
      vecs[5] = '{48'h0000_0B7A_B6A5, 7, 11, 0, 7, 0, 1};
`endif

      reset = 1'b0;
      hold  = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'hD;
      #3;
      chk("rst result", int'(result), 0);
      chk("rst result_valid", int'(result_valid), 0);
      chk("rst error", int'(error), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst entry_sel", int'(entry_sel), 0);
      chk("rst digit_count", int'(digit_count), 0);
      chk("rst number1", int'(bus.number1), 0);
      chk("rst number2", int'(bus.number2), 0);
      chk("rst add_enable", int'(bus.add_enable), 0);
      tick();
      reset = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) begin
         logic [47:0] kk;
         kk = vecs[v].keys;
         send_key(4'hC, 1);
         for (int j = 0; j < vecs[v].n; j++) send_key(kk[4*j +: 4], 3);
         chk($sformatf("vec%0d result", v), int'(result), vecs[v].res);
         chk($sformatf("vec%0d result_valid", v), int'(result_valid), vecs[v].valid);
         chk($sformatf("vec%0d number1", v), int'(bus.number1), vecs[v].n1);
         chk($sformatf("vec%0d number2", v), int'(bus.number2), vecs[v].n2);
         chk($sformatf("vec%0d digit_count", v), int'(digit_count), vecs[v].dc);
      end

      // Latency: '=' sampled at E -> ADD in E..E+1, result valid from E+2.
      send_key(4'hC, 0);
      send_key(4'h1, 0);
      send_key(4'hA, 0);
      send_key(4'h2, 0);
      send_key(4'hB, 0);
      chk("lat add_enable E", int'(bus.add_enable), 1);
      chk("lat busy E", int'(busy), 1);
      tick();
      chk("lat add_enable E+1", int'(bus.add_enable), 0);
      chk("lat busy E+1", int'(busy), 1);
      chk("lat valid E+1", int'(result_valid), 0);
      tick();
      chk("lat valid E+2", int'(result_valid), 1);
      chk("lat result E+2", int'(result), 3);
      chk("lat busy E+2", int'(busy), 0);

      // Timeout with the adder never answering.
      hold = 1'b1;
      send_key(4'hC, 0);
      send_key(4'h4, 0);
      send_key(4'hA, 0);
      send_key(4'h5, 0);
      send_key(4'hB, 0);
      send_key(4'h6, 0);
      for (int i = 0; i < TO - 1; i++) tick();
      chk("to error before", int'(error), 0);
      chk("to busy before", int'(busy), 1);
      tick();
      chk("to error", int'(error), 1);
      chk("to result", int'(result), 0);
      chk("to result_valid", int'(result_valid), 0);
      chk("to busy after", int'(busy), 0);
      hold = 1'b0;
      send_key(4'h7, 0);
      chk("to new error", int'(error), 0);
      chk("to new number1", int'(bus.number1), 7);
      chk("to new number2", int'(bus.number2), 0);
      chk("to new digit_count", int'(digit_count), 1);

      // Clear on the same edge as sum_state.
      send_key(4'hC, 0);
      send_key(4'h1, 0);
      send_key(4'hA, 0);
      send_key(4'h2, 0);
      send_key(4'hB, 0);
      tick();
      chk("clr sum_state present", int'(bus.sum_state), 1);
      send_key(4'hC, 0);
      chk("clr result_valid", int'(result_valid), 0);
      chk("clr result", int'(result), 0);
      chk("clr busy", int'(busy), 0);
      chk("clr entry_sel", int'(entry_sel), 0);
      chk("clr number1", int'(bus.number1), 0);
      for (int i = 0; i < 3; i++) tick();
      chk("clr valid later", int'(result_valid), 0);

      // Reset asserted during ADD, checked with no clock edge.
      send_key(4'h3, 0);
      send_key(4'hA, 0);
      send_key(4'h4, 0);
      send_key(4'hB, 0);
      chk("rstadd add_enable before", int'(bus.add_enable), 1);
      reset = 1'b0;
      #1;
      chk("rstadd add_enable", int'(bus.add_enable), 0);
      chk("rstadd busy", int'(busy), 0);
      chk("rstadd number1", int'(bus.number1), 0);
      chk("rstadd number2", int'(bus.number2), 0);
      chk("rstadd digit_count", int'(digit_count), 0);
      chk("rstadd entry_sel", int'(entry_sel), 0);
      #2;
      reset = 1'b1;
      tick();

      // Random key stream against the calculator model.
      model_clear();
      send_key(4'hC, 3);
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 19));
         if (r < 10)      k = 4'(r);
         else if (r < 13) k = 4'hA;
         else if (r < 16) k = 4'hB;
         else if (r == 16) k = 4'hC;
         else             k = 4'(r - 4);
         model_key(k);
         send_key(k, 3);
         chk("rnd number1", int'(bus.number1), ma);
         chk("rnd number2", int'(bus.number2), mb);
         chk("rnd digit_count", int'(digit_count), mdc);
         chk("rnd entry_sel", int'(entry_sel), (mph == 1) ? 1 : 0);
         chk("rnd result", int'(result), mres);
         chk("rnd result_valid", int'(result_valid), int'(mval));
         chk("rnd error", int'(error), int'(merr));
         chk("rnd busy", int'(busy), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
